fetch_unit: RTL and testbench

Multi-cycle instruction fetch stage and instruction register for the CPU core. Issues word reads to instruction memory over a req/ready handshake, latches the returned instruction, and holds it stable while the multi-cycle controller steps through decode, execute and writeback. Drives the 25-bit immediate field (instr[31:7]) consumed by the immediate extender, plus the register/opcode fields, the current PC and PC+4.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 9 +
 rtl/instr_fields.sv | 21 ++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM states, NOP encoding and instruction field widths
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int OPCODE_W = 7;
  localparam int REG_W = 5;
  localparam int IMM_FIELD_W = 25;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read channel (req/addr out, ready/rdata back)
interface fetch_unit_if;
  logic req;
  logic [31:0] addr;
  logic ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/instr_fields.sv
// instr_fields: slices an instruction word into its opcode, register and immediate fields
module instr_fields
  import cpu_pkg::*;
(
  input  logic [31:0]            instr,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [REG_W-1:0]       rd,
  output logic [FUNCT3_W-1:0]    funct3,
  output logic [REG_W-1:0]       rs1,
  output logic [REG_W-1:0]       rs2,
  output logic [FUNCT7_W-1:0]    funct7,
  output logic [IMM_FIELD_W-1:0] imm_field
);
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7    = instr[31:25];
  assign imm_field = instr[31:7];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch FSM, PC and instruction register
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_start,
  input  logic                   pc_load,
  input  logic [31:0]            pc_target,
  fetch_unit_if.master           imem,
  output logic [31:0]            instr,
  output logic [IMM_FIELD_W-1:0] imm_field,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [REG_W-1:0]       rd,
  output logic [FUNCT3_W-1:0]    funct3,
  output logic [REG_W-1:0]       rs1,
  output logic [REG_W-1:0]       rs2,
  output logic [FUNCT7_W-1:0]    funct7,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            pc_instr,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   fetch_err
);
  fetch_state_t state, next;
  logic [31:0] cnt, eff;
  logic timeout;
  assign eff      = pc_load ? pc_target : pc;
  assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt + 32'd1 == 32'(TIMEOUT_CYCLES));
  assign pc_plus4 = pc + 32'd4;
  always_comb begin
    next = state;
    if (state == FETCH) next = imem.ready ? HOLD : timeout ? ERR : FETCH;
    else if (state != ERR && fetch_start) next = (eff[1:0] != 2'b00) ? ERR : FETCH;
  end
  // status outputs are decoded from next state so they are registered with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_instr    <= RESET_PC;
      instr       <= NOP_INSTR;
      imem.req    <= 1'b0;
      imem.addr   <= RESET_PC;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= next;
      imem.req    <= next == FETCH;
      busy        <= next == FETCH;
      instr_valid <= next == HOLD;
      fetch_err   <= next == ERR;
      if (state == FETCH) begin
        cnt <= imem.ready ? '0 : cnt + 32'd1;
        if (imem.ready) begin
          instr    <= imem.rdata;
          pc_instr <= imem.addr;
          pc       <= imem.addr + 32'd4;
        end
      end else if (state != ERR) begin
        if (next == FETCH) imem.addr <= eff;
        else if (pc_load && !fetch_start) pc <= pc_target;
      end
    end
  end
  instr_fields u_fields (
    .instr(instr), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm_field(imm_field)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values
module tb_fetch_unit;
  import cpu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, fetch_start = 1'b0, pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] instr, pc, pc_plus4, pc_instr;
  logic [IMM_FIELD_W-1:0] imm_field;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [FUNCT3_W-1:0] funct3;
  logic [FUNCT7_W-1:0] funct7;
  logic instr_valid, busy, fetch_err;
  int checks = 0, passed = 0;
  fetch_unit_if imem();
  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_target(pc_target), .imem(imem), .instr(instr), .imm_field(imm_field),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4), .pc_instr(pc_instr),
    .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic reset_dut;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    imem.ready = 1'b0;
    imem.rdata = '0;
    tick();
    reset_dut();
    check("rst_pc", pc, 0);
    check("rst_pc_instr", pc_instr, 0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_req", imem.req, 0);
    check("rst_addr", imem.addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", fetch_err, 0);
    // zero-wait fetch
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f0_req", imem.req, 1);
    check("f0_addr", imem.addr, 0);
    check("f0_busy", busy, 1);
    check("f0_valid", instr_valid, 0);
    imem.ready = 1'b1;
    imem.rdata = 32'h00A00093;
    tick();
    imem.ready = 1'b0;
    check("f0_valid_hold", instr_valid, 1);
    check("f0_instr", instr, 32'h00A00093);
    check("f0_rd", rd, 1);
    check("f0_imm", imm_field, 25'h0014001);
    check("f0_opcode", opcode, 7'h13);
    check("f0_pc", pc, 4);
    check("f0_pc_plus4", pc_plus4, 8);
    check("f0_pc_instr", pc_instr, 0);
    check("f0_req_off", imem.req, 0);
    check("f0_busy_off", busy, 0);
    // three wait states
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_req", imem.req, 1);
      check("ws_addr", imem.addr, 4);
      check("ws_busy", busy, 1);
      tick();
    end
    check("ws_req4", imem.req, 1);
    check("ws_addr4", imem.addr, 4);
    check("ws_busy4", busy, 1);
    imem.ready = 1'b1;
    imem.rdata = 32'h002081B3;
    tick();
    imem.ready = 1'b0;
    check("ws_instr", instr, 32'h002081B3);
    check("ws_rd", rd, 3);
    check("ws_rs1", rs1, 1);
    check("ws_rs2", rs2, 2);
    check("ws_funct7", funct7, 0);
    check("ws_pc", pc, 8);
    check("ws_pc_instr", pc_instr, 4);
    check("ws_valid", instr_valid, 1);
    check("ws_err", fetch_err, 0);
    // redirect plus fetch in the same cycle
    pc_load = 1'b1;
    pc_target = 32'h100;
    fetch_start = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch_start = 1'b0;
    check("br_addr", imem.addr, 32'h100);
    check("br_req", imem.req, 1);
    imem.ready = 1'b1;
    imem.rdata = 32'hFFF00113;
    tick();
    imem.ready = 1'b0;
    check("br_pc", pc, 32'h104);
    check("br_pc_instr", pc_instr, 32'h100);
    check("br_imm", imm_field, 25'h1FFE002);
    check("br_rd", rd, 2);
    // redirect without fetch keeps the instruction
    pc_load = 1'b1;
    pc_target = 32'h200;
    tick();
    pc_load = 1'b0;
    check("ld_pc", pc, 32'h200);
    check("ld_pc_plus4", pc_plus4, 32'h204);
    check("ld_instr", instr, 32'hFFF00113);
    check("ld_valid", instr_valid, 1);
    check("ld_req", imem.req, 0);
    // PC wrap at top of address space
    pc_load = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    fetch_start = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch_start = 1'b0;
    check("wr_addr", imem.addr, 32'hFFFF_FFFC);
    imem.ready = 1'b1;
    imem.rdata = 32'h00000013;
    tick();
    imem.ready = 1'b0;
    check("wr_pc", pc, 0);
    check("wr_pc_plus4", pc_plus4, 4);
    check("wr_pc_instr", pc_instr, 32'hFFFF_FFFC);
    // misaligned redirect
    pc_load = 1'b1;
    pc_target = 32'h102;
    fetch_start = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch_start = 1'b0;
    check("mis_err", fetch_err, 1);
    check("mis_req", imem.req, 0);
    check("mis_valid", instr_valid, 0);
    check("mis_busy", busy, 0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("mis_sticky", fetch_err, 1);
    check("mis_sticky_req", imem.req, 0);
    reset_dut();
    check("mis_rst_err", fetch_err, 0);
    check("mis_rst_pc", pc, 0);
    // timeout after four FETCH cycles
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("to_req_c4", imem.req, 1);
    check("to_err_c4", fetch_err, 0);
    tick();
    check("to_err", fetch_err, 1);
    check("to_req", imem.req, 0);
    check("to_busy", busy, 0);
    reset_dut();
    // reset in the middle of a fetch
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem.ready = 1'b1;
    imem.rdata = 32'h00500113;
    tick();
    imem.ready = 1'b0;
    check("mr_instr", instr, 32'h00500113);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    check("mr_req_pre", imem.req, 1);
    reset_dut();
    check("mr_req", imem.req, 0);
    check("mr_pc", pc, 0);
    check("mr_instr_nop", instr, NOP_INSTR);
    check("mr_valid", instr_valid, 0);
    imem.ready = 1'b1;
    imem.rdata = 32'hDEADBEEF;
    tick();
    imem.ready = 1'b0;
    check("late_instr", instr, NOP_INSTR);
    check("late_valid", instr_valid, 0);
    check("late_pc", pc, 0);
    check("late_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
